// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one single-cycle combinational ALU between two requesters.
//
// Handshake rules:
//   Request side: req[n] is held together with its operands until ack[n]
//   pulses. ack[n] is a registered one-cycle pulse that appears in the cycle
//   after acceptance. Response side: rsp_valid_o[n] stays high, and the
//   response fields stay stable, until rsp_ready_i[n] is seen high on a
//   rising clock edge. ready on the non-owning port is ignored.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req_i[1:0]                 per-port request
//   op*_i, a*_i, b*_i, sh*_i   per-port op code, operands, shift amount
//   ack_o[1:0]                 acceptance pulse
//   rsp_valid_o / rsp_ready_i  per-port response handshake
//   rsp_data_o, rsp_zero_o, rsp_neg_o, rsp_err_o   shared response fields
//   alu_*_o                    operands held on the ALU inputs
//   alu_out_i, alu_zero_i, alu_neg_i   ALU result and flags
//   busy_o                     high outside IDLE
//   dbg_state                  current FSM state (IDLE=0, EXEC=1, RESP=2)
module alu_arbiter #(
  parameter int WIDTH     = 32,
  parameter int SHORT_LAT = 1,
  parameter int LONG_LAT  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_i,
  input  logic [3:0]       op0_i,
  input  logic [3:0]       op1_i,
  input  logic [WIDTH-1:0] a0_i,
  input  logic [WIDTH-1:0] a1_i,
  input  logic [WIDTH-1:0] b0_i,
  input  logic [WIDTH-1:0] b1_i,
  input  logic [4:0]       sh0_i,
  input  logic [4:0]       sh1_i,
  output logic [1:0]       ack_o,
  output logic [1:0]       rsp_valid_o,
  input  logic [1:0]       rsp_ready_i,
  output logic [WIDTH-1:0] rsp_data_o,
  output logic             rsp_zero_o,
  output logic             rsp_neg_o,
  output logic             rsp_err_o,
  output logic [WIDTH-1:0] alu_data1_o,
  output logic [WIDTH-1:0] alu_data2_o,
  output logic [3:0]       alu_op_o,
  output logic [4:0]       alu_shamt_o,
  input  logic [WIDTH-1:0] alu_out_i,
  input  logic             alu_zero_i,
  input  logic             alu_neg_i,
  output logic             busy_o,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int MAX_LAT = (LONG_LAT > SHORT_LAT) ? LONG_LAT : SHORT_LAT;
  localparam int CNT_W   = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT);
  localparam logic [CNT_W-1:0] SHORT_LD = CNT_W'(SHORT_LAT - 1);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_LAT - 1);

  state_t             state, state_n;
  logic               ptr;       // port favoured when both request
  logic               port;      // owner of the operation in flight
  logic [CNT_W-1:0]   cnt;

  // Winner selection and operand muxing for the IDLE cycle
  logic               winner;
  logic [3:0]         sel_op;
  logic [WIDTH-1:0]   sel_a, sel_b;
  logic [4:0]         sel_sh;
  logic               sel_long, sel_illegal;
  logic               accept, capture, handshake;

  always_comb begin
    winner      = 1'b0;
    sel_op      = op0_i;
    sel_a       = a0_i;
    sel_b       = b0_i;
    sel_sh      = sh0_i;
    sel_long    = 1'b0;
    sel_illegal = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    handshake   = 1'b0;
    state_n     = state;

    winner = (req_i == 2'b11) ? ptr : req_i[1];
    if (winner) begin
      sel_op = op1_i;
      sel_a  = a1_i;
      sel_b  = b1_i;
      sel_sh = sh1_i;
    end
    sel_long    = (sel_op == 4'b1100) || (sel_op == 4'b1101) || (sel_op == 4'b1110);
    // Divide and remainder by zero are rejected before they reach the ALU
    sel_illegal = (sel_op == 4'b1111) ||
                  (((sel_op == 4'b1101) || (sel_op == 4'b1110)) && (sel_b == '0));

    case (state)
      IDLE: begin
        if (req_i != 2'b00) begin
          accept  = 1'b1;
          state_n = sel_illegal ? RESP : EXEC;
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          capture = 1'b1;
          state_n = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i[port]) begin
          handshake = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      port        <= 1'b0;
      cnt         <= '0;
      ack_o       <= 2'b00;
      rsp_data_o  <= '0;
      rsp_zero_o  <= 1'b0;
      rsp_neg_o   <= 1'b0;
      rsp_err_o   <= 1'b0;
      alu_data1_o <= '0;
      alu_data2_o <= '0;
      alu_op_o    <= 4'b0000;
      alu_shamt_o <= '0;
    end else begin
      state <= state_n;
      ack_o <= 2'b00;

      if (accept) begin
        port  <= winner;
        ack_o <= winner ? 2'b10 : 2'b01;
        if (sel_illegal) begin
          // ALU inputs are left untouched so an illegal op is never visible there
          rsp_data_o <= '0;
          rsp_zero_o <= 1'b0;
          rsp_neg_o  <= 1'b0;
          rsp_err_o  <= 1'b1;
        end else begin
          alu_op_o    <= sel_op;
          alu_data1_o <= sel_a;
          alu_data2_o <= sel_b;
          alu_shamt_o <= sel_sh;
          cnt         <= sel_long ? LONG_LD : SHORT_LD;
        end
      end

      if (state == EXEC && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end

      if (capture) begin
        rsp_data_o <= alu_out_i;
        rsp_zero_o <= alu_zero_i;
        rsp_neg_o  <= alu_neg_i;
        rsp_err_o  <= 1'b0;
      end

      if (handshake) begin
        ptr <= ~port;
      end
    end
  end

  assign rsp_valid_o = (state == RESP) ? (port ? 2'b10 : 2'b01) : 2'b00;
  assign busy_o      = (state != IDLE);
  assign dbg_state   = state;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_i;
  logic [3:0]   op0_i, op1_i;
  logic [W-1:0] a0_i, a1_i, b0_i, b1_i;
  logic [4:0]   sh0_i, sh1_i;
  logic [1:0]   ack_o, rsp_valid_o, rsp_ready_i;
  logic [W-1:0] rsp_data_o;
  logic         rsp_zero_o, rsp_neg_o, rsp_err_o;
  logic [W-1:0] alu_data1_o, alu_data2_o;
  logic [3:0]   alu_op_o;
  logic [4:0]   alu_shamt_o;
  logic [W-1:0] alu_out_i;
  logic         alu_zero_i, alu_neg_i;
  logic         busy_o;
  logic [1:0]   dbg_state;

  int errors = 0;
  int checks = 0;

  alu_arbiter #(.WIDTH(W), .SHORT_LAT(1), .LONG_LAT(4)) dut (
    .clk(clk), .rst(rst), .req_i(req_i),
    .op0_i(op0_i), .op1_i(op1_i), .a0_i(a0_i), .a1_i(a1_i),
    .b0_i(b0_i), .b1_i(b1_i), .sh0_i(sh0_i), .sh1_i(sh1_i),
    .ack_o(ack_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_zero_o(rsp_zero_o), .rsp_neg_o(rsp_neg_o),
    .rsp_err_o(rsp_err_o), .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o),
    .alu_op_o(alu_op_o), .alu_shamt_o(alu_shamt_o), .alu_out_i(alu_out_i),
    .alu_zero_i(alu_zero_i), .alu_neg_i(alu_neg_i), .busy_o(busy_o),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Small reference ALU attached to the DUT's ALU port
  always_comb begin
    case (alu_op_o)
      4'b0000: alu_out_i = alu_data1_o;
      4'b0001: alu_out_i = alu_data1_o + alu_data2_o;
      4'b0010: alu_out_i = alu_data1_o - alu_data2_o;
      4'b1100: alu_out_i = alu_data1_o * alu_data2_o;
      4'b1101: alu_out_i = (alu_data2_o != 0) ? alu_data1_o / alu_data2_o : '0;
      4'b1110: alu_out_i = (alu_data2_o != 0) ? alu_data1_o % alu_data2_o : '0;
      default: alu_out_i = alu_data1_o & alu_data2_o;
    endcase
    alu_zero_i = (alu_out_i == '0);
    alu_neg_i  = alu_out_i[W-1];
  end

  // Inputs change and outputs are sampled on the falling edge
  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 12; i++) begin
      if (!busy_o) begin
        done = 1;
        break;
      end
      step();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain: busy_o still %b after 12 cycles, want 0", name, busy_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_i = 2'b00; rsp_ready_i = 2'b00;
    op0_i = 4'h0; op1_i = 4'h0; a0_i = '0; a1_i = '0; b0_i = '0; b1_i = '0;
    sh0_i = '0; sh1_i = '0;
    repeat (3) step();
    checks++;
    if ({busy_o, ack_o, rsp_valid_o, dbg_state} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy/ack/valid/state=%b/%b/%b/%0d want 0/00/00/0",
               busy_o, ack_o, rsp_valid_o, dbg_state);
    end
    checks++;
    if ({alu_op_o, alu_data1_o, alu_data2_o, alu_shamt_o} !== '0) begin
      errors++;
      $display("FAIL reset_alu: op=%h d1=%h d2=%h sh=%h want all 0",
               alu_op_o, alu_data1_o, alu_data2_o, alu_shamt_o);
    end
    checks++;
    if ({rsp_data_o, rsp_zero_o, rsp_neg_o, rsp_err_o} !== '0) begin
      errors++;
      $display("FAIL reset_rsp: data=%h z=%b n=%b e=%b want 0", rsp_data_o,
               rsp_zero_o, rsp_neg_o, rsp_err_o);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_short_add();
    rsp_ready_i = 2'b11;
    req_i = 2'b01; op0_i = 4'b0001; a0_i = 5; b0_i = 7; sh0_i = 5'd3;
    step();  // accepted on this edge
    checks++;
    if (ack_o !== 2'b01 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL short_ack: ack=%b busy=%b want 01/1", ack_o, busy_o);
    end
    checks++;
    if (alu_op_o !== 4'b0001 || alu_data1_o !== 5 || alu_data2_o !== 7 || alu_shamt_o !== 5'd3) begin
      errors++;
      $display("FAIL short_alu_in: op=%h d1=%0d d2=%0d sh=%0d want 1/5/7/3",
               alu_op_o, alu_data1_o, alu_data2_o, alu_shamt_o);
    end
    req_i = 2'b00;
    step();
    checks++;
    if (ack_o !== 2'b00 || rsp_valid_o !== 2'b01 || rsp_data_o !== 12 ||
        {rsp_zero_o, rsp_neg_o, rsp_err_o} !== 3'b000) begin
      errors++;
      $display("FAIL short_rsp: ack=%b valid=%b data=%0d zne=%b%b%b want 00/01/12/000",
               ack_o, rsp_valid_o, rsp_data_o, rsp_zero_o, rsp_neg_o, rsp_err_o);
    end
    step();
    checks++;
    if (busy_o !== 1'b0 || rsp_valid_o !== 2'b00) begin
      errors++;
      $display("FAIL short_turnaround: busy=%b valid=%b want 0/00 three cycles after request",
               busy_o, rsp_valid_o);
    end
  endtask

  task automatic test_long_mul();
    req_i = 2'b10; op1_i = 4'b1100; a1_i = 6; b1_i = 7;
    step();
    checks++;
    if (ack_o !== 2'b10) begin
      errors++;
      $display("FAIL long_ack: ack=%b want 10", ack_o);
    end
    req_i = 2'b00;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (alu_op_o !== 4'b1100 || rsp_valid_o !== 2'b00 || dbg_state !== 2'd1) begin
        errors++;
        $display("FAIL long_hold_%0d: op=%h valid=%b state=%0d want c/00/1",
                 i, alu_op_o, rsp_valid_o, dbg_state);
      end
      step();
    end
    checks++;
    if (rsp_valid_o !== 2'b10 || rsp_data_o !== 42 || rsp_err_o !== 1'b0) begin
      errors++;
      $display("FAIL long_rsp: valid=%b data=%0d err=%b want 10/42/0",
               rsp_valid_o, rsp_data_o, rsp_err_o);
    end
    step();
  endtask

  task automatic test_fairness();
    logic [1:0]   acks [3];
    logic [W+3:0] rsps [2];
    int na = 0, nr = 0;
    req_i = 2'b11;
    op0_i = 4'b0010; a0_i = 3; b0_i = 3;
    op1_i = 4'b0010; a1_i = 1; b1_i = 2;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ack_o != 2'b00 && na < 3) begin
        acks[na] = ack_o;
        na++;
      end
      if (rsp_valid_o != 2'b00 && nr < 2) begin
        rsps[nr] = {rsp_valid_o, rsp_zero_o, rsp_neg_o, rsp_data_o};
        nr++;
      end
      if (na == 3 && nr == 2) break;
    end
    req_i = 2'b00;
    checks++;
    if (na != 3 || nr != 2) begin
      errors++;
      $display("FAIL fair_count: acks=%0d rsps=%0d want 3/2", na, nr);
    end else begin
      checks++;
      if ({acks[0], acks[1], acks[2]} !== 6'b01_10_01) begin
        errors++;
        $display("FAIL fair_order: acks=%b,%b,%b want 01,10,01", acks[0], acks[1], acks[2]);
      end
      checks++;
      if (rsps[0] !== {2'b01, 2'b10, 32'h0000_0000}) begin
        errors++;
        $display("FAIL fair_rsp0: valid/z/n/data=%h want 01/1/0/00000000", rsps[0]);
      end
      checks++;
      if (rsps[1] !== {2'b10, 2'b01, 32'hFFFF_FFFF}) begin
        errors++;
        $display("FAIL fair_rsp1: valid/z/n/data=%h want 10/0/1/ffffffff", rsps[1]);
      end
    end
    wait_idle("fair");
  endtask

  task automatic test_illegal();
    logic [3:0] ops [2];
    logic [W-1:0] bs [2];
    ops[0] = 4'b1101; bs[0] = 0;
    ops[1] = 4'b1111; bs[1] = 4;
    for (int k = 0; k < 2; k++) begin
      req_i = 2'b01; op0_i = ops[k]; a0_i = 9; b0_i = bs[k];
      step();
      checks++;
      if (dbg_state !== 2'd2 || ack_o !== 2'b01 || rsp_valid_o !== 2'b01) begin
        errors++;
        $display("FAIL illegal%0d_path: state=%0d ack=%b valid=%b want 2/01/01",
                 k, dbg_state, ack_o, rsp_valid_o);
      end
      checks++;
      if (rsp_err_o !== 1'b1 || rsp_data_o !== 0 || {rsp_zero_o, rsp_neg_o} !== 2'b00) begin
        errors++;
        $display("FAIL illegal%0d_rsp: err=%b data=%h zn=%b%b want 1/0/00",
                 k, rsp_err_o, rsp_data_o, rsp_zero_o, rsp_neg_o);
      end
      checks++;
      if (alu_op_o !== 4'b0010) begin
        errors++;
        $display("FAIL illegal%0d_alu_op: op=%h want 2 (unchanged)", k, alu_op_o);
      end
      req_i = 2'b00;
      step();
      checks++;
      if (busy_o !== 1'b0) begin
        errors++;
        $display("FAIL illegal%0d_done: busy=%b want 0", k, busy_o);
      end
    end
  endtask

  task automatic test_stall();
    rsp_ready_i = 2'b10;  // ready only on the non-owning port
    req_i = 2'b01; op0_i = 4'b0001; a0_i = 1; b0_i = 2;
    step();
    checks++;
    if (ack_o !== 2'b01) begin
      errors++;
      $display("FAIL stall_ack0: ack=%b want 01", ack_o);
    end
    req_i = 2'b10; op1_i = 4'b0001; a1_i = 10; b1_i = 20;
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid_o !== 2'b01 || rsp_data_o !== 3 || ack_o !== 2'b00 || dbg_state !== 2'd2) begin
        errors++;
        $display("FAIL stall_hold_%0d: valid=%b data=%0d ack=%b state=%0d want 01/3/00/2",
                 i, rsp_valid_o, rsp_data_o, ack_o, dbg_state);
      end
      step();
    end
    rsp_ready_i = 2'b11;
    step();
    checks++;
    if (rsp_valid_o !== 2'b00 || ack_o !== 2'b00 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: valid=%b ack=%b busy=%b want 00/00/0",
               rsp_valid_o, ack_o, busy_o);
    end
    step();
    checks++;
    if (ack_o !== 2'b10) begin
      errors++;
      $display("FAIL stall_ack1: ack=%b want 10", ack_o);
    end
    req_i = 2'b00;
    step();
    checks++;
    if (rsp_valid_o !== 2'b10 || rsp_data_o !== 30) begin
      errors++;
      $display("FAIL stall_rsp1: valid=%b data=%0d want 10/30", rsp_valid_o, rsp_data_o);
    end
    step();
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    // Port 0 completes first so the pointer moves to port 1
    req_i = 2'b01; op0_i = 4'b0000; a0_i = 77; b0_i = 0;
    step();
    req_i = 2'b00;
    step();
    checks++;
    if (rsp_valid_o !== 2'b01 || rsp_data_o !== 77) begin
      errors++;
      $display("FAIL rmid_pre: valid=%b data=%0d want 01/77", rsp_valid_o, rsp_data_o);
    end
    step();
    req_i = 2'b10; op1_i = 4'b1100; a1_i = 3; b1_i = 5;
    step();
    req_i = 2'b00;
    step();  // mid-EXEC
    rst = 1'b1;
    step();
    checks++;
    if ({busy_o, dbg_state, ack_o, rsp_valid_o} !== 7'b0 || alu_op_o !== 4'b0000) begin
      errors++;
      $display("FAIL rmid_reset: busy=%b state=%0d ack=%b valid=%b op=%h want 0/0/00/00/0",
               busy_o, dbg_state, ack_o, rsp_valid_o, alu_op_o);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rsp_valid_o != 2'b00) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rmid_no_rsp: response seen after reset, want none");
    end
    // Pointer must be back at 0: port 0 wins a simultaneous request
    req_i = 2'b11; op0_i = 4'b0001; a0_i = 1; b0_i = 1; op1_i = 4'b0001; a1_i = 100; b1_i = 1;
    step();
    checks++;
    if (ack_o !== 2'b01) begin
      errors++;
      $display("FAIL rmid_ptr: ack=%b want 01", ack_o);
    end
    req_i = 2'b00;
    wait_idle("rmid");
    req_i = 2'b10;
    step();
    checks++;
    if (ack_o !== 2'b10) begin
      errors++;
      $display("FAIL rmid_ack1: ack=%b want 10", ack_o);
    end
    req_i = 2'b00;
    step();
    checks++;
    if (rsp_valid_o !== 2'b10 || rsp_data_o !== 101 || rsp_err_o !== 1'b0) begin
      errors++;
      $display("FAIL rmid_rsp1: valid=%b data=%0d err=%b want 10/101/0",
               rsp_valid_o, rsp_data_o, rsp_err_o);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_short_add();
    test_long_mul();
    test_fairness();
    test_illegal();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
